// File: rtl/core_pkg.sv
// core_pkg: shared types and helpers for the pipeline sequencing logic.
//   state_t      - memory-access sequencer state (IDLE / WAIT)
//   REG_ZERO     - architectural $zero register index
//   hazard_match - true when a load destination feeds a source operand
package core_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // $zero is never a real dependency, so a load targeting it never stalls.
    function automatic logic hazard_match(input logic [4:0] dst, input logic [4:0] src);
        return (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/mem_stall_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use comparator.
//   idexmemread - ID/EX instruction is a load
//   idexrt      - destination register of that load
//   ifidrs      - rs of the IF/ID instruction
//   ifidrt      - rt of the IF/ID instruction
//   lu          - load-use hazard: one bubble is required
module hazard_detect
    import core_pkg::*;
(
    input  logic       idexmemread,
    input  logic [4:0] idexrt,
    input  logic [4:0] ifidrs,
    input  logic [4:0] ifidrt,
    output logic       lu
);

    always_comb begin
        lu = idexmemread &
             (hazard_match(idexrt, ifidrs) | hazard_match(idexrt, ifidrt));
    end

endmodule

// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl: pipeline sequencing controller for the 5-stage MIPS core.
//   clk, rst_n                  - clock, synchronous active-low reset
//   exmmemread / exmmemwrite    - EX/MEM holds a load / store
//   dmem_ack                    - data memory completes the access this cycle
//   idexmemread, idexrt         - ID/EX load and its destination
//   ifidrs, ifidrt              - IF/ID source registers
//   dmem_req                    - data-memory request (combinational)
//   pc_en, ifid_en, idex_en,
//   exm_en, mwb_en              - stage register enables
//   idex_flush                  - load a bubble into ID/EX
//   mem_err                     - sticky access-timeout flag
//   stall_cnt                   - saturating count of stall cycles
module mem_stall_ctrl
    import core_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             exmmemread,
    input  logic             exmmemwrite,
    input  logic             dmem_ack,
    input  logic             idexmemread,
    input  logic [4:0]       idexrt,
    input  logic [4:0]       ifidrs,
    input  logic [4:0]       ifidrt,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exm_en,
    output logic             mwb_en,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WC_W = $clog2(MAX_WAIT + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(MAX_WAIT);

    state_t          state, state_nxt;
    logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
    logic            memop;
    logic            req_raw;
    logic            mem_stall;
    logic            mem_timeout;
    logic            lu;

    assign memop = exmmemread | exmmemwrite;

    hazard_detect u_hazard_detect (
        .idexmemread (idexmemread),
        .idexrt      (idexrt),
        .ifidrs      (ifidrs),
        .ifidrt      (ifidrt),
        .lu          (lu)
    );

    // Access sequencer. An ack always takes priority over the timeout check.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        req_raw      = 1'b0;
        mem_stall    = 1'b0;
        mem_timeout  = 1'b0;
        case (state)
            IDLE: begin
                req_raw = memop;
                if (memop && !dmem_ack) begin
                    mem_stall    = 1'b1;
                    state_nxt    = WAIT;
                    wait_cnt_nxt = WC_W'(1);
                end
            end
            WAIT: begin
                req_raw = 1'b1;
                if (dmem_ack) begin
                    state_nxt    = IDLE;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt < WC_MAX) begin
                    mem_stall    = 1'b1;
                    wait_cnt_nxt = wait_cnt + WC_W'(1);
                end else begin
                    mem_timeout  = 1'b1;
                    state_nxt    = IDLE;
                    wait_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = IDLE;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // Stage control: memory freeze beats the load-use bubble.
    always_comb begin
        dmem_req   = 1'b0;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        idex_flush = 1'b0;
        exm_en     = 1'b1;
        mwb_en     = 1'b1;
        if (rst_n) begin
            dmem_req = req_raw;
            if (mem_stall) begin
                // MEM/WB freezes too so its value stays valid for WB forwarding.
                pc_en   = 1'b0;
                ifid_en = 1'b0;
                idex_en = 1'b0;
                exm_en  = 1'b0;
                mwb_en  = 1'b0;
            end else if (lu) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (mem_timeout) begin
                mem_err <= 1'b1;
            end
            if ((mem_stall || lu) && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// tb_mem_stall_ctrl: self-checking bench for mem_stall_ctrl.
// Directed vectors from a table, a counter saturation sequence, then random
// stimulus checked against a behavioural model.
module tb_mem_stall_ctrl;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 6;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    // ctrl bit order: {dmem_req, pc_en, ifid_en, idex_en, idex_flush, exm_en, mwb_en}
    localparam logic [6:0] C_RUN        = 7'b0111011;
    localparam logic [6:0] C_RUN_REQ    = 7'b1111011;
    localparam logic [6:0] C_FREEZE_REQ = 7'b1000000;
    localparam logic [6:0] C_LU         = 7'b0001111;
    localparam logic [6:0] C_LU_REQ     = 7'b1001111;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             exmmemread, exmmemwrite, dmem_ack, idexmemread;
    logic [4:0]       idexrt, ifidrs, ifidrt;
    logic             dmem_req, pc_en, ifid_en, idex_en, idex_flush, exm_en, mwb_en;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;

    mem_stall_ctrl #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .exmmemread  (exmmemread),
        .exmmemwrite (exmmemwrite),
        .dmem_ack    (dmem_ack),
        .idexmemread (idexmemread),
        .idexrt      (idexrt),
        .ifidrs      (ifidrs),
        .ifidrt      (ifidrt),
        .dmem_req    (dmem_req),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .idex_en     (idex_en),
        .idex_flush  (idex_flush),
        .exm_en      (exm_en),
        .mwb_en      (mwb_en),
        .mem_err     (mem_err),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model: an access is "outstanding" with a count of cycles
    // it has already been waited on.
    bit m_busy;
    int m_waited;
    bit m_err;
    int m_cnt;

    typedef struct {
        logic       rst_n, rd, wr, ack, idrd;
        logic [4:0] idrt, rs, rt;
        logic [6:0] ctrl;
        logic       err;
        int         cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [6:0] dut_ctrl();
        return {dmem_req, pc_en, ifid_en, idex_en, idex_flush, exm_en, mwb_en};
    endfunction

    function automatic bit model_lu();
        return idexmemread && (idexrt != 0) && (idexrt == ifidrs || idexrt == ifidrt);
    endfunction

    function automatic bit model_mem_stall();
        bit memop = exmmemread | exmmemwrite;
        if (!m_busy) return memop && !dmem_ack;
        return !dmem_ack && (m_waited < MAX_WAIT);
    endfunction

    function automatic logic [6:0] model_ctrl();
        bit req;
        if (!rst_n) return C_RUN;
        req = m_busy || exmmemread || exmmemwrite;
        if (model_mem_stall()) return {req, 6'b000000};
        if (model_lu())        return {req, 6'b001111};
        return {req, 6'b111011};
    endfunction

    task automatic model_edge();
        bit stall_now;
        if (!rst_n) begin
            m_busy = 0; m_waited = 0; m_err = 0; m_cnt = 0;
            return;
        end
        stall_now = model_mem_stall() || model_lu();
        if (m_busy) begin
            if (dmem_ack) begin
                m_busy = 0;
            end else if (m_waited >= MAX_WAIT) begin
                m_busy = 0;
                m_err  = 1;
            end else begin
                m_waited++;
            end
        end else if ((exmmemread || exmmemwrite) && !dmem_ack) begin
            m_busy   = 1;
            m_waited = 1;
        end
        if (stall_now && m_cnt < CNT_MAX) m_cnt++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rd, input logic wr, input logic ack,
                         input logic idrd, input logic [4:0] idrt,
                         input logic [4:0] rs, input logic [4:0] rt);
        rst_n = r; exmmemread = rd; exmmemwrite = wr; dmem_ack = ack;
        idexmemread = idrd; idexrt = idrt; ifidrs = rs; ifidrt = rt;
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic add(input logic r, input logic rd, input logic wr, input logic ack,
                       input logic idrd, input logic [4:0] idrt,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [6:0] ctrl, input logic err, input int cnt);
        vec_t v;
        v.rst_n = r; v.rd = rd; v.wr = wr; v.ack = ack; v.idrd = idrd;
        v.idrt = idrt; v.rs = rs; v.rt = rt; v.ctrl = ctrl; v.err = err; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        finish_cycle();
        finish_cycle();

        //   rst rd wr ak ir irt rs rt   ctrl           err cnt
        add(0, 0, 0, 0, 0, 0, 0, 0,    C_RUN,         0,  0);  // reset state
        add(1, 0, 0, 0, 0, 0, 0, 0,    C_RUN,         0,  0);
        add(1, 1, 0, 1, 0, 0, 0, 0,    C_RUN_REQ,     0,  0);  // zero-wait load
        add(1, 0, 0, 0, 0, 0, 0, 0,    C_RUN,         0,  0);
        add(1, 0, 1, 0, 0, 0, 0, 0,    C_FREEZE_REQ,  0,  0);  // 3-wait store
        add(1, 0, 1, 0, 0, 0, 0, 0,    C_FREEZE_REQ,  0,  1);
        add(1, 0, 1, 0, 0, 0, 0, 0,    C_FREEZE_REQ,  0,  2);
        add(1, 0, 1, 1, 0, 0, 0, 0,    C_RUN_REQ,     0,  3);
        add(1, 0, 0, 0, 0, 0, 0, 0,    C_RUN,         0,  3);
        add(1, 0, 0, 0, 1, 8, 8, 0,    C_LU,          0,  3);  // load-use on rs
        add(1, 0, 0, 0, 0, 0, 0, 0,    C_RUN,         0,  4);
        add(1, 0, 0, 0, 1, 0, 0, 0,    C_RUN,         0,  4);  // $zero: no stall
        add(1, 0, 0, 0, 1, 9, 3, 9,    C_LU,          0,  4);  // load-use on rt
        add(1, 1, 0, 0, 1, 8, 8, 0,    C_FREEZE_REQ,  0,  5);  // freeze beats lu
        add(1, 1, 0, 0, 1, 8, 8, 0,    C_FREEZE_REQ,  0,  6);
        add(1, 1, 0, 1, 1, 8, 8, 0,    C_LU_REQ,      0,  7);
        add(1, 0, 0, 0, 0, 0, 0, 0,    C_RUN,         0,  8);
        add(1, 1, 0, 0, 0, 0, 0, 0,    C_FREEZE_REQ,  0,  8);  // timeout
        add(1, 1, 0, 0, 0, 0, 0, 0,    C_FREEZE_REQ,  0,  9);
        add(1, 1, 0, 0, 0, 0, 0, 0,    C_FREEZE_REQ,  0, 10);
        add(1, 1, 0, 0, 0, 0, 0, 0,    C_FREEZE_REQ,  0, 11);
        add(1, 1, 0, 0, 0, 0, 0, 0,    C_RUN_REQ,     0, 12);
        add(1, 0, 0, 0, 0, 0, 0, 0,    C_RUN,         1, 12);
        add(1, 0, 0, 0, 0, 0, 0, 0,    C_RUN,         1, 12);  // sticky
        add(0, 0, 0, 0, 0, 0, 0, 0,    C_RUN,         1, 12);
        add(1, 0, 0, 0, 0, 0, 0, 0,    C_RUN,         0,  0);
        add(1, 1, 0, 0, 0, 0, 0, 0,    C_FREEZE_REQ,  0,  0);  // ack at the limit
        add(1, 1, 0, 0, 0, 0, 0, 0,    C_FREEZE_REQ,  0,  1);
        add(1, 1, 0, 0, 0, 0, 0, 0,    C_FREEZE_REQ,  0,  2);
        add(1, 1, 0, 0, 0, 0, 0, 0,    C_FREEZE_REQ,  0,  3);
        add(1, 1, 0, 1, 0, 0, 0, 0,    C_RUN_REQ,     0,  4);
        add(1, 0, 0, 0, 0, 0, 0, 0,    C_RUN,         0,  4);
        add(1, 0, 1, 0, 0, 0, 0, 0,    C_FREEZE_REQ,  0,  4);  // reset mid-WAIT
        add(1, 0, 1, 0, 0, 0, 0, 0,    C_FREEZE_REQ,  0,  5);
        add(0, 0, 1, 0, 0, 0, 0, 0,    C_RUN,         0,  6);
        add(1, 0, 0, 0, 0, 0, 0, 0,    C_RUN,         0,  0);
        add(1, 0, 0, 0, 0, 0, 0, 0,    C_RUN,         0,  0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst_n, tbl[i].rd, tbl[i].wr, tbl[i].ack,
                  tbl[i].idrd, tbl[i].idrt, tbl[i].rs, tbl[i].rt);
            @(negedge clk);
            chk($sformatf("vec%0d ctrl", i), 32'(dut_ctrl()), 32'(tbl[i].ctrl));
            chk($sformatf("vec%0d mem_err", i), 32'(mem_err), 32'(tbl[i].err));
            chk($sformatf("vec%0d stall_cnt", i), 32'(stall_cnt), 32'(tbl[i].cnt));
            finish_cycle();
        end

        // Saturation: hold a load-use hazard well past the counter range.
        for (int i = 0; i < CNT_MAX + 6; i++) begin
            drive(1, 0, 0, 0, 1, 5, 5, 5);
            finish_cycle();
        end
        @(negedge clk);
        chk("stall_cnt saturated", 32'(stall_cnt), 32'(CNT_MAX));
        chk("lu ctrl while saturated", 32'(dut_ctrl()), 32'(C_LU));
        finish_cycle();
        @(negedge clk);
        chk("stall_cnt holds at max", 32'(stall_cnt), 32'(CNT_MAX));

        // Random phase against the model.
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        finish_cycle();
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
                  ($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0,
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)));
            @(negedge clk);
            chk($sformatf("rnd%0d ctrl", i), 32'(dut_ctrl()), 32'(model_ctrl()));
            chk($sformatf("rnd%0d mem_err", i), 32'(mem_err), 32'(m_err));
            chk($sformatf("rnd%0d stall_cnt", i), 32'(stall_cnt), 32'(m_cnt));
            finish_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stall_ctrl.md
Name: mem_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Drives the enable and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB stage registers.
- Sequences each data-memory access over a req/ack handshake with variable wait states, and freezes the pipeline until the access completes.
- Also detects load-use hazards and inserts one bubble into ID/EX. Keeps a saturating stall-cycle counter and a sticky memory-timeout error flag.

Parameters:
- MAX_WAIT, 16: maximum wait cycles in WAIT before a timeout is declared; legal range 1..255.
- CNT_W, 32: width of the stall_cnt performance counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- exmmemread  in  1  instruction in EX/MEM is a load
- exmmemwrite  in  1  instruction in EX/MEM is a store
- dmem_ack  in  1  data memory completes the current access this cycle
- idexmemread  in  1  instruction in ID/EX is a load
- idexrt  in  5  destination register of the ID/EX load
- ifidrs  in  5  rs field of the instruction in IF/ID
- ifidrt  in  5  rt field of the instruction in IF/ID
- dmem_req  out  1  data-memory access request
- pc_en  out  1  PC update enable
- ifid_en  out  1  IF/ID register enable
- idex_en  out  1  ID/EX register enable
- idex_flush  out  1  load a bubble (all control bits 0) into ID/EX
- exm_en  out  1  EX/MEM register enable
- mwb_en  out  1  MEM/WB register enable
- mem_err  out  1  sticky flag: an access timed out
- stall_cnt  out  CNT_W  total stall cycles, saturating

Behaviour:
- memop = exmmemread | exmmemwrite.
- Registered state: IDLE or WAIT, plus wait_cnt of width clog2(MAX_WAIT+1), mem_err and stall_cnt.
- Reset (rst_n low at a clk edge):
  - state becomes IDLE; wait_cnt, mem_err and stall_cnt become 0.
  - While rst_n is low, the combinational outputs are forced: dmem_req=0, all enables=1, idex_flush=0.
  - Reset during WAIT abandons the access; dmem_req is low from the first reset cycle.
- dmem_req = (IDLE & memop) | WAIT. It is combinational, so a zero-wait memory completes in the same cycle.
- IDLE, memop=1, dmem_ack=1: access completes with no stall; remain in IDLE.
- IDLE, memop=1, dmem_ack=0: mem_stall=1 this cycle; go to WAIT with wait_cnt=1.
- IDLE, memop=0: dmem_ack is ignored.
- WAIT, dmem_ack=1: mem_stall=0 this cycle, so the stage registers advance at this edge; go to IDLE with wait_cnt=0.
- WAIT, dmem_ack=0, wait_cnt<MAX_WAIT: mem_stall=1; wait_cnt increments.
- WAIT, dmem_ack=0, wait_cnt=MAX_WAIT: mem_stall=0; mem_err is set (sticky until reset); go to IDLE and release the pipeline. The load result is undefined.
- ack and timeout in the same cycle: ack wins; mem_err is not set.
- Load-use: lu = idexmemread & (idexrt!=0) & (idexrt==ifidrs | idexrt==ifidrt).
- Control priority:
  - mem_stall=1: all five enables are 0 (full freeze, MEM/WB included so WB forwarding stays valid); idex_flush=0.
  - else lu=1: pc_en=0, ifid_en=0, idex_flush=1; idex_en=1, exm_en=1, mwb_en=1. This lasts exactly 1 cycle, because the bubble clears idexmemread.
  - else: all enables 1, idex_flush=0.
- stall_cnt increments by 1 on every cycle where mem_stall or lu is 1 (at most +1 per cycle) and saturates at all-ones.

Decomposition:
- Shared package core_pkg holds:
  - state enum {IDLE, WAIT};
  - the REG_ZERO=5'd0 constant;
  - the hazard-compare helper function.
- One natural sub-module: hazard_detect, a purely combinational load-use comparator producing lu. The FSM, counters and control muxing stay in the top module.

Test Plan:
- Zero-wait load: exmmemread=1 with dmem_ack=1 in the same cycle -> dmem_req=1, all enables 1, state stays IDLE, stall_cnt stays 0.
- 3-wait store: exmmemwrite=1, dmem_ack rises 3 cycles after req -> dmem_req high for 4 cycles, enables 0 for 3 cycles, advance on the 4th, stall_cnt=3.
- Load-use: idexmemread=1, idexrt=5'd8, ifidrs=5'd8 -> for one cycle pc_en=0, ifid_en=0, idex_flush=1. Repeat with idexrt=0 -> no stall.
- Stall priority: load-use present while in WAIT -> idex_flush=0 and all enables 0 until ack, then load-use bubble on the next cycle.
- Timeout: MAX_WAIT=4, ack never arrives -> 4 stall cycles, then mem_err=1, enables=1, state IDLE. mem_err stays 1 until rst_n is pulsed.
- Reset mid-WAIT: assert rst_n=0 on the 2nd wait cycle -> dmem_req=0 immediately; after release state IDLE, stall_cnt=0, mem_err=0.
